remove_arb: RTL and testbench

REMOVE_ARB -- requirements
Module: remove_arb

---
 rtl/remove_pkg.sv | 16 +
 rtl/remove_rr_arb.sv | 20 ++
 rtl/remove_arb.sv | 128 ++++++++++++
 tb/tb_remove_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/remove_pkg.sv
// Shared definitions for the remove-command arbiter: FSM state encoding and
// default width constants.
// Contents: state_t (IDLE/CMD/XFER), DEF_DATA_WD, DEF_DATA_BYTE_WD, DEF_BYTE_CNT_WD.
package remove_pkg;

    localparam int DEF_DATA_WD      = 32;
    localparam int DEF_DATA_BYTE_WD = DEF_DATA_WD / 8;
    localparam int DEF_BYTE_CNT_WD  = $clog2(DEF_DATA_BYTE_WD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        XFER = 2'd2
    } state_t;

endpackage

// File: rtl/remove_rr_arb.sv
// Two-way round-robin pick: the source not granted last wins a tie, a lone
// requester wins outright. Purely combinational, zero latency, no backpressure.
// Ports: req[1:0] requests, last_grant previous winner, gnt winning index.
module remove_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt
);

    always_comb begin
        // Tie (or no request) goes to the other source than last time.
        gnt = ~last_grant;
        if (req == 2'b01) begin
            gnt = 1'b0;
        end else if (req == 2'b10) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/remove_arb.sv
// Packet-granular 2:1 arbiter feeding a byte-remove datapath: each granted
// packet first issues a remove command, then its beats are forwarded.
// Latency: valid -> command 1 cycle, command accept -> first beat 1 cycle,
// last beat -> next grant 1 cycle. Backpressure: m_ready passes straight to
// the granted source; sources are held off entirely until the command is taken.
// Ports: clk/rst; s0_*/s1_* AXI-stream sources with sN_remove_cnt; m_* stream
// out; valid_remove/byte_remove_cnt/ready_remove command handshake; grant index.
// Optional macro REMOVE_ARB_STATS_EN adds 16-bit per-source packet counters
// pkt_cnt0/pkt_cnt1.
module remove_arb
    import remove_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s0_valid,
    input  logic [DATA_WD-1:0]      s0_data,
    input  logic                    s0_last,
    input  logic [DATA_BYTE_WD-1:0] s0_keep,
    output logic                    s0_ready,
    input  logic [BYTE_CNT_WD-1:0]  s0_remove_cnt,

    input  logic                    s1_valid,
    input  logic [DATA_WD-1:0]      s1_data,
    input  logic                    s1_last,
    input  logic [DATA_BYTE_WD-1:0] s1_keep,
    output logic                    s1_ready,
    input  logic [BYTE_CNT_WD-1:0]  s1_remove_cnt,

    output logic                    m_valid,
    output logic [DATA_WD-1:0]      m_data,
    output logic                    m_last,
    output logic [DATA_BYTE_WD-1:0] m_keep,
    input  logic                    m_ready,

    output logic                    valid_remove,
    output logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    input  logic                    ready_remove,

    output logic                    grant
`ifdef REMOVE_ARB_STATS_EN
    ,
    output logic [15:0]             pkt_cnt0,
    output logic [15:0]             pkt_cnt1
`endif
);

    state_t state;
    logic   last_grant;
    logic   arb_gnt;
    logic   in_xfer;
    logic   last_fire;

    remove_rr_arb u_rr_arb (
        .req        ({s1_valid, s0_valid}),
        .last_grant (last_grant),
        .gnt        (arb_gnt)
    );

    // valid_remove is a registered copy of "state == CMD".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            grant           <= 1'b0;
            last_grant      <= 1'b1;
            byte_remove_cnt <= '0;
            valid_remove    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        state           <= CMD;
                        grant           <= arb_gnt;
                        last_grant      <= arb_gnt;
                        byte_remove_cnt <= arb_gnt ? s1_remove_cnt : s0_remove_cnt;
                        valid_remove    <= 1'b1;
                    end
                end
                CMD: begin
                    if (ready_remove) begin
                        state        <= XFER;
                        valid_remove <= 1'b0;
                    end
                end
                XFER: begin
                    // A stalled source simply leaves us here with grant held.
                    if (last_fire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    valid_remove <= 1'b0;
                end
            endcase
        end
    end

    // Stream path is only opened once the command has been accepted.
    assign in_xfer   = (state == XFER);
    assign m_valid   = in_xfer & (grant ? s1_valid : s0_valid);
    assign m_data    = grant ? s1_data : s0_data;
    assign m_last    = grant ? s1_last : s0_last;
    assign m_keep    = grant ? s1_keep : s0_keep;
    assign s0_ready  = in_xfer & ~grant & m_ready;
    assign s1_ready  = in_xfer &  grant & m_ready;
    assign last_fire = m_valid & m_ready & m_last;

`ifdef REMOVE_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (last_fire) begin
            if (grant) begin
                pkt_cnt1 <= pkt_cnt1 + 16'd1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_remove_arb.sv
// Directed bench for remove_arb: reset state, single-source packet, tie
// arbitration, command stall, output backpressure, mid-packet reset and
// (with REMOVE_ARB_STATS_EN) packet counters.
module tb_remove_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_last, s0_ready;
    logic [31:0] s0_data;
    logic [3:0]  s0_keep;
    logic [1:0]  s0_remove_cnt;
    logic        s1_valid, s1_last, s1_ready;
    logic [31:0] s1_data;
    logic [3:0]  s1_keep;
    logic [1:0]  s1_remove_cnt;
    logic        m_valid, m_last, m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        valid_remove, ready_remove, grant;
    logic [1:0]  byte_remove_cnt;
`ifdef REMOVE_ARB_STATS_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int idx;
    int cyc;
    logic fired;
    logic [31:0] e_beats [4];

    always #5 clk = ~clk;

    remove_arb dut (
        .clk             (clk),
        .rst             (rst),
        .s0_valid        (s0_valid),
        .s0_data         (s0_data),
        .s0_last         (s0_last),
        .s0_keep         (s0_keep),
        .s0_ready        (s0_ready),
        .s0_remove_cnt   (s0_remove_cnt),
        .s1_valid        (s1_valid),
        .s1_data         (s1_data),
        .s1_last         (s1_last),
        .s1_keep         (s1_keep),
        .s1_ready        (s1_ready),
        .s1_remove_cnt   (s1_remove_cnt),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_last          (m_last),
        .m_keep          (m_keep),
        .m_ready         (m_ready),
        .valid_remove    (valid_remove),
        .byte_remove_cnt (byte_remove_cnt),
        .ready_remove    (ready_remove),
`ifdef REMOVE_ARB_STATS_EN
        .pkt_cnt0        (pkt_cnt0),
        .pkt_cnt1        (pkt_cnt1),
`endif
        .grant           (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_vrem"}, valid_remove, 0);
        chk({tag, "_bcnt"}, byte_remove_cnt, 0);
        chk({tag, "_mvalid"}, m_valid, 0);
        chk({tag, "_s0rdy"}, s0_ready, 0);
        chk({tag, "_s1rdy"}, s1_ready, 0);
    endtask

    // Single-beat packet from one source, everything else ready.
    task automatic send_pkt(input logic src, input logic [1:0] cnt, input logic [31:0] d);
        if (!src) begin
            s0_valid = 1'b1; s0_data = d; s0_last = 1'b1; s0_remove_cnt = cnt;
        end else begin
            s1_valid = 1'b1; s1_data = d; s1_last = 1'b1; s1_remove_cnt = cnt;
        end
        tick();
        chk("pkt_grant", grant, src);
        chk("pkt_bcnt", byte_remove_cnt, cnt);
        tick();
        chk("pkt_data", m_data, d);
        tick();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s0_valid = 0; s0_data = '0; s0_last = 0; s0_keep = 4'hF; s0_remove_cnt = 0;
        s1_valid = 0; s1_data = '0; s1_last = 0; s1_keep = 4'hF; s1_remove_cnt = 0;
        m_ready = 0; ready_remove = 0;
        e_beats[0] = 32'hE000_0000; e_beats[1] = 32'hE111_1111;
        e_beats[2] = 32'hE222_2222; e_beats[3] = 32'hE333_3333;

        // Reset state
        tick(); tick();
        chk_reset_outs("rst");
`ifdef REMOVE_ARB_STATS_EN
        chk("rst_pc0", pkt_cnt0, 0);
        chk("rst_pc1", pkt_cnt1, 0);
`endif
        rst = 1'b0;

        // S0 only, 3 beats, remove_cnt 2
        s0_valid = 1; s0_data = 32'hA0; s0_last = 0; s0_remove_cnt = 2'd2;
        ready_remove = 1; m_ready = 1;
        #1;
        chk("s1_idle_vrem", valid_remove, 0);
        chk("s1_idle_mvalid", m_valid, 0);
        chk("s1_idle_s0rdy", s0_ready, 0);
        tick();
        chk("s1_cmd_vrem", valid_remove, 1);
        chk("s1_cmd_bcnt", byte_remove_cnt, 2);
        chk("s1_cmd_grant", grant, 0);
        chk("s1_cmd_mvalid", m_valid, 0);
        chk("s1_cmd_s0rdy", s0_ready, 0);
        tick();
        chk("s1_x_vrem", valid_remove, 0);
        chk("s1_b0_mvalid", m_valid, 1);
        chk("s1_b0_data", m_data, 32'hA0);
        chk("s1_b0_last", m_last, 0);
        chk("s1_b0_s0rdy", s0_ready, 1);
        tick();
        s0_data = 32'hA1;
        #1;
        chk("s1_b1_data", m_data, 32'hA1);
        tick();
        s0_data = 32'hA2; s0_last = 1;
        #1;
        chk("s1_b2_data", m_data, 32'hA2);
        chk("s1_b2_last", m_last, 1);
        chk("s1_b2_grant", grant, 0);
        tick();
        s0_valid = 0;
        #1;
        chk("s1_end_mvalid", m_valid, 0);
        chk("s1_end_vrem", valid_remove, 0);
        chk("s1_end_bcnt", byte_remove_cnt, 2);

        // Tie right after reset: S0 first, S1 next, S0's second packet waits
        rst = 1; tick(); rst = 0;
        s0_valid = 1; s0_data = 32'hB0; s0_last = 1; s0_remove_cnt = 2'd1;
        s1_valid = 1; s1_data = 32'hC0; s1_last = 1; s1_remove_cnt = 2'd3;
        tick();
        chk("s2_g0", grant, 0);
        chk("s2_bcnt0", byte_remove_cnt, 1);
        tick();
        chk("s2_d0", m_data, 32'hB0);
        chk("s2_s1rdy0", s1_ready, 0);
        tick();
        s0_data = 32'hB1;
        #1;
        chk("s2_gap_mvalid", m_valid, 0);
        chk("s2_gap_s0rdy", s0_ready, 0);
        tick();
        chk("s2_g1", grant, 1);
        chk("s2_bcnt1", byte_remove_cnt, 3);
        chk("s2_vrem1", valid_remove, 1);
        tick();
        chk("s2_d1", m_data, 32'hC0);
        chk("s2_s1rdy1", s1_ready, 1);
        chk("s2_s0rdy1", s0_ready, 0);
        tick();
        s1_valid = 0;
        tick();
        chk("s2_g2", grant, 0);
        tick();
        chk("s2_d2", m_data, 32'hB1);
        tick();
        s0_valid = 0;

        // Command stalled by ready_remove = 0
        ready_remove = 0;
        s0_valid = 1; s0_data = 32'hD0; s0_last = 1; s0_remove_cnt = 2'd3;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s3_vrem", valid_remove, 1);
            chk("s3_bcnt", byte_remove_cnt, 3);
            chk("s3_mvalid", m_valid, 0);
            chk("s3_s0rdy", s0_ready, 0);
            chk("s3_s1rdy", s1_ready, 0);
            tick();
        end
        chk("s3_still_vrem", valid_remove, 1);
        ready_remove = 1;
        tick();
        chk("s3_acc_vrem", valid_remove, 0);
        chk("s3_acc_data", m_data, 32'hD0);
        chk("s3_acc_mvalid", m_valid, 1);
        tick();
        s0_valid = 0;

        // S1 4-beat packet with m_ready toggling
        s1_valid = 1; s1_remove_cnt = 2'd1; s1_keep = 4'h3; s1_last = 0;
        s1_data = e_beats[0];
        tick();
        chk("s4_grant_cmd", grant, 1);
        tick();
        idx = 0; cyc = 0;
        while (idx < 4 && cyc < 16) begin
            s1_data = e_beats[idx];
            s1_last = (idx == 3);
            m_ready = (cyc % 2 == 0);
            #1;
            chk("s4_mvalid", m_valid, 1);
            chk("s4_data", m_data, e_beats[idx]);
            chk("s4_last", m_last, (idx == 3) ? 1 : 0);
            chk("s4_keep", m_keep, 4'h3);
            chk("s4_s1rdy", s1_ready, m_ready);
            chk("s4_s0rdy", s0_ready, 0);
            chk("s4_grant", grant, 1);
            fired = m_ready;
            tick();
            if (fired) idx++;
            cyc++;
        end
        chk("s4_beats", idx, 4);
        chk("s4_cycles", cyc, 7);
        s1_valid = 0; s1_keep = 4'hF; m_ready = 1;
        #1;
        chk("s4_end_mvalid", m_valid, 0);

        // Reset during beat 2 of 4
        s0_valid = 1; s0_data = 32'hF0; s0_last = 0; s0_remove_cnt = 2'd2;
        tick(); tick(); tick();
        s0_data = 32'hF1;
        #1;
        chk("s5_b2_data", m_data, 32'hF1);
        rst = 1;
        tick();
        chk_reset_outs("s5_rst");
        rst = 0;
        s0_data = 32'h60; s0_last = 1; s0_remove_cnt = 2'd1;
        #1;
        chk("s5_rel_vrem", valid_remove, 0);
        chk("s5_rel_mvalid", m_valid, 0);
        tick();
        chk("s5_cmd_vrem", valid_remove, 1);
        chk("s5_cmd_bcnt", byte_remove_cnt, 1);
        tick();
        chk("s5_data", m_data, 32'h60);
        tick();
        s0_valid = 0;

        // 3 packets from S0, 2 from S1 after a fresh reset
        rst = 1; tick(); rst = 0;
        send_pkt(1'b0, 2'd0, 32'h1000);
        send_pkt(1'b1, 2'd1, 32'h2000);
        send_pkt(1'b0, 2'd2, 32'h1001);
        send_pkt(1'b1, 2'd3, 32'h2001);
        send_pkt(1'b0, 2'd1, 32'h1002);
`ifdef REMOVE_ARB_STATS_EN
        chk("st_pc0", pkt_cnt0, 3);
        chk("st_pc1", pkt_cnt1, 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
